// File: rtl/butterfly2_pipe.sv
// butterfly2_pipe: 3-stage radix-2 DIT butterfly with rounding, optional /2 scaling, saturation and sticky overflow.
// Define BUTTERFLY2_PIPE_CONJ_EN to add i_inverse (conjugated twiddle for the IFFT).
module butterfly2_pipe #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_scale,
`ifdef BUTTERFLY2_PIPE_CONJ_EN
    input  logic         i_inverse,
`endif
    input  logic [N-1:0] i_in0_re,
    input  logic [N-1:0] i_in0_im,
    input  logic [N-1:0] i_in1_re,
    input  logic [N-1:0] i_in1_im,
    input  logic [N-1:0] i_twiddle_re,
    input  logic [N-1:0] i_twiddle_im,
    input  logic         i_clr_ovf,
    output logic         o_valid,
    output logic [N-1:0] o_out0_re,
    output logic [N-1:0] o_out0_im,
    output logic [N-1:0] o_out1_re,
    output logic [N-1:0] o_out1_im,
    output logic         o_ovf
);
    localparam int m = 2 * N;
    localparam logic signed [m:0] half = (m + 1)'(1) <<< (Q - 1);

    // {overflow, value} results: saturate product sum to N+1 bits, final sums to N bits
    function automatic logic [N+1:0] sat_t(input logic signed [m:0] v);
        return (&v[m:N] || !(|v[m:N])) ? {1'b0, v[N:0]} : {1'b1, v[m], {N{~v[m]}}};
    endfunction

    function automatic logic [N:0] sat_o(input logic signed [N+1:0] v);
        return (&v[N+1:N-1] || !(|v[N+1:N-1])) ? {1'b0, v[N-1:0]} : {1'b1, v[N+1], {(N-1){~v[N+1]}}};
    endfunction

    function automatic logic signed [N+1:0] scl(input logic signed [N+1:0] v, input logic s);
        return s ? (v + (N + 2)'(1)) >>> 1 : v;
    endfunction

    logic                s1_valid, s1_scale;
    logic signed [N-1:0] s1_x0_re, s1_x0_im, s1_ar, s1_ai, s1_wr, s1_wi, wi;
`ifdef BUTTERFLY2_PIPE_CONJ_EN
    logic                s1_inv;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_x0_re <= '0;
            s1_x0_im <= '0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
`ifdef BUTTERFLY2_PIPE_CONJ_EN
            s1_inv   <= 1'b0;
`endif
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_scale <= i_scale;
                s1_x0_re <= i_in0_re;
                s1_x0_im <= i_in0_im;
                s1_ar    <= i_in1_re;
                s1_ai    <= i_in1_im;
                s1_wr    <= i_twiddle_re;
                s1_wi    <= i_twiddle_im;
`ifdef BUTTERFLY2_PIPE_CONJ_EN
                s1_inv   <= i_inverse;
`endif
            end
        end
    end

`ifdef BUTTERFLY2_PIPE_CONJ_EN
    // the most negative twiddle has no positive counterpart, so clamp its negation
    assign wi = !s1_inv ? s1_wi : (s1_wi == {1'b1, {(N-1){1'b0}}}) ? {1'b0, {(N-1){1'b1}}} : -s1_wi;
`else
    assign wi = s1_wi;
`endif

    logic signed [m-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [m:0]   r_re, r_im;
    logic [N+1:0]        st_re, st_im;
    assign p_rr  = s1_ar * s1_wr;
    assign p_ii  = s1_ai * wi;
    assign p_ri  = s1_ar * wi;
    assign p_ir  = s1_ai * s1_wr;
    assign r_re  = (p_rr - p_ii + half) >>> Q;
    assign r_im  = (p_ri + p_ir + half) >>> Q;
    assign st_re = sat_t(r_re);
    assign st_im = sat_t(r_im);

    logic                s2_valid, s2_scale, s2_sat;
    logic signed [N-1:0] s2_x0_re, s2_x0_im;
    logic signed [N:0]   s2_t_re, s2_t_im;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_sat   <= 1'b0;
            s2_x0_re <= '0;
            s2_x0_im <= '0;
            s2_t_re  <= '0;
            s2_t_im  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_scale <= s1_scale;
                s2_sat   <= st_re[N+1] | st_im[N+1];
                s2_x0_re <= s1_x0_re;
                s2_x0_im <= s1_x0_im;
                s2_t_re  <= st_re[N:0];
                s2_t_im  <= st_im[N:0];
            end
        end
    end

    logic signed [N+1:0] a0_re, a0_im, a1_re, a1_im;
    logic [N:0]          r0_re, r0_im, r1_re, r1_im;
    assign a0_re = s2_x0_re + s2_t_re;
    assign a0_im = s2_x0_im + s2_t_im;
    assign a1_re = s2_x0_re - s2_t_re;
    assign a1_im = s2_x0_im - s2_t_im;
    assign r0_re = sat_o(scl(a0_re, s2_scale));
    assign r0_im = sat_o(scl(a0_im, s2_scale));
    assign r1_re = sat_o(scl(a1_re, s2_scale));
    assign r1_im = sat_o(scl(a1_im, s2_scale));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_out0_re <= '0;
            o_out0_im <= '0;
            o_out1_re <= '0;
            o_out1_im <= '0;
            o_ovf     <= 1'b0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_out0_re <= r0_re[N-1:0];
                o_out0_im <= r0_im[N-1:0];
                o_out1_re <= r1_re[N-1:0];
                o_out1_im <= r1_im[N-1:0];
            end
            // a new saturation wins over a clear in the same cycle
            o_ovf <= (s2_valid && (s2_sat || r0_re[N] || r0_im[N] || r1_re[N] || r1_im[N]))
                     || (o_ovf && !i_clr_ovf);
        end
    end
endmodule

// File: tb/tb_butterfly2_pipe.sv
// tb_butterfly2_pipe: directed vectors with hand-computed results for butterfly2_pipe (N=16, Q=8).
module tb_butterfly2_pipe;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_scale = 1'b0, i_clr_ovf = 1'b0;
`ifdef BUTTERFLY2_PIPE_CONJ_EN
    logic        i_inverse = 1'b0;
`endif
    logic [15:0] i_in0_re = '0, i_in0_im = '0, i_in1_re = '0, i_in1_im = '0;
    logic [15:0] i_twiddle_re = '0, i_twiddle_im = '0;
    logic        o_valid, o_ovf;
    logic [15:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

    always #5 i_clk = ~i_clk;

    butterfly2_pipe #(.N(16), .Q(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_scale(i_scale),
`ifdef BUTTERFLY2_PIPE_CONJ_EN
        .i_inverse(i_inverse),
`endif
        .i_in0_re(i_in0_re), .i_in0_im(i_in0_im), .i_in1_re(i_in1_re), .i_in1_im(i_in1_im),
        .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im), .i_clr_ovf(i_clr_ovf),
        .o_valid(o_valid), .o_out0_re(o_out0_re), .o_out0_im(o_out0_im),
        .o_out1_re(o_out1_re), .o_out1_im(o_out1_im), .o_ovf(o_ovf)
    );

    // in0_re in0_im in1_re in1_im w_re w_im scale | out0_re out0_im out1_re out1_im saturates
    logic [15:0] tv [0:7][0:11] = '{
        '{16'h0200, 16'h0300, 16'hFC00, 16'h0200, 16'h0300, 16'hFF00, 16'h0, 16'hF800, 16'h0D00, 16'h0C00, 16'hF900, 16'h0},
        '{16'h0200, 16'h0300, 16'hFC00, 16'h0200, 16'h0300, 16'hFF00, 16'h1, 16'hFC00, 16'h0680, 16'h0600, 16'hFC80, 16'h0},
        '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0},
        '{16'h6400, 16'h0000, 16'h6400, 16'h0000, 16'h0100, 16'h0000, 16'h0, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h1},
        '{16'h6400, 16'h0000, 16'h6400, 16'h0000, 16'h0100, 16'h0000, 16'h1, 16'h6400, 16'h0000, 16'h0000, 16'h0000, 16'h0},
        '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 16'h1},
        '{16'h0100, 16'hFF80, 16'h0180, 16'hFE80, 16'h00B5, 16'hFF4B, 16'h0, 16'h0100, 16'hFD61, 16'h0100, 16'h019F, 16'h0},
        '{16'h0100, 16'hFF80, 16'h0180, 16'hFE80, 16'h00B5, 16'hFF4B, 16'h1, 16'h0080, 16'hFEB1, 16'h0080, 16'h00D0, 16'h0}
    };

    int          n_vec = 0, n_err = 0;
    logic        pv [3] = '{1'b0, 1'b0, 1'b0};
    int          pidx [3] = '{0, 0, 0};
    logic        clr_prev = 1'b0, eovf = 1'b0;
    logic [15:0] h [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("o_valid", {15'b0, o_valid}, {15'b0, pv[2]});
        chk("out0_re", o_out0_re, h[0]);
        chk("out0_im", o_out0_im, h[1]);
        chk("out1_re", o_out1_re, h[2]);
        chk("out1_im", o_out1_im, h[3]);
        chk("o_ovf", {15'b0, o_ovf}, {15'b0, eovf});
    endtask

    // one clock: check what the last edge produced, then drive the next input set
    task automatic step(input logic v, input int idx, input logic clr);
        @(negedge i_clk);
        if (pv[2]) for (int k = 0; k < 4; k++) h[k] = tv[pidx[2]][7+k];
        eovf = (pv[2] && tv[pidx[2]][11][0]) || (eovf && !clr_prev);
        chk_all();
        pv[2] = pv[1]; pidx[2] = pidx[1];
        pv[1] = pv[0]; pidx[1] = pidx[0];
        pv[0] = v;     pidx[0] = idx;
        clr_prev = clr;
        i_valid = v;
        i_clr_ovf = clr;
        i_in0_re = tv[idx][0];
        i_in0_im = tv[idx][1];
        i_in1_re = tv[idx][2];
        i_in1_im = tv[idx][3];
        i_twiddle_re = tv[idx][4];
        i_twiddle_im = tv[idx][5];
        i_scale = tv[idx][6][0];
    endtask

    initial begin
        #12;
        chk_all();
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1, 0, 0); repeat (4) step(0, 0, 0);
        step(1, 1, 0); repeat (3) step(0, 0, 0);
        step(1, 2, 0); repeat (3) step(0, 0, 0);
        step(1, 3, 0); step(0, 0, 0); step(1, 0, 0); repeat (4) step(0, 0, 0);
        step(0, 0, 1); repeat (2) step(0, 0, 0);
        step(1, 4, 0); repeat (3) step(0, 0, 0);
        step(0, 3, 0); repeat (3) step(0, 0, 0);
        step(1, 5, 0); repeat (3) step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 0);
        step(1, 3, 0); step(0, 0, 0); step(0, 0, 1); repeat (3) step(0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, i, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, i, 0);
            step(0, 0, 0);
        end
        step(1, 0, 0);
        step(1, 6, 0);
        step(1, 7, 0);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        pv = '{1'b0, 1'b0, 1'b0};
        h = '{16'h0, 16'h0, 16'h0, 16'h0};
        eovf = 1'b0;
        clr_prev = 1'b0;
        chk_all();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = 1'b0;
        repeat (6) step(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
